// File: rtl/wisc_pkg.sv
// Shared ISA constants for the WISC pipeline: opcodes, flag bit positions
// and the per-opcode condition-flag write mask.
package wisc_pkg;

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_XOR = 4'b0010;
  localparam logic [3:0] OP_SLL = 4'b0100;
  localparam logic [3:0] OP_SRA = 4'b0101;
  localparam logic [3:0] OP_ROR = 4'b0110;
  localparam logic [3:0] OP_LW  = 4'b1000;
  localparam logic [3:0] OP_SW  = 4'b1001;
  localparam logic [3:0] OP_HLT = 4'b1111;

  localparam int FLAG_Z = 2;
  localparam int FLAG_V = 1;
  localparam int FLAG_N = 0;

  // Arithmetic writes all three flags; logic/shift ops only write Z.
  function automatic logic [2:0] flag_mask(input logic [3:0] op);
    case (op)
      OP_ADD, OP_SUB:                 flag_mask = 3'b111;
      OP_XOR, OP_SLL, OP_SRA, OP_ROR: flag_mask = 3'b100;
      default:                        flag_mask = 3'b000;
    endcase
  endfunction

endpackage

// File: rtl/ex_mem_flag_reg_flag_unit.sv
// Condition-flag register {Z,V,N} with per-opcode write mask and a
// combinational look-ahead of the post-edge flag value.
module flag_unit
  import wisc_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             upd,
  input  logic [3:0]       opcode,
  input  logic [WIDTH-1:0] result,
  input  logic             ovf,
  output logic             flag_z,
  output logic             flag_v,
  output logic             flag_n,
  output logic [2:0]       flags_fwd
);

  logic [2:0] flags, cand, mask, nxt;

  always_comb begin
    cand         = '0;
    cand[FLAG_Z] = (result == '0);
    cand[FLAG_V] = ovf;
    cand[FLAG_N] = result[WIDTH-1];
    mask         = upd ? flag_mask(opcode) : 3'b000;
    nxt          = (cand & mask) | (flags & ~mask);
  end

  // While reset is held the value after the next edge is all zeros.
  assign flags_fwd = rst ? 3'b000 : nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) flags <= '0;
    else     flags <= nxt;
  end

  assign flag_z = flags[FLAG_Z];
  assign flag_v = flags[FLAG_V];
  assign flag_n = flags[FLAG_N];

endmodule

// File: rtl/ex_mem_flag_reg.sv
// EX/MEM pipeline register with condition flags, stall/flush handling and
// a sticky halt that turns every later slot into a bubble until reset.
module ex_mem_flag_reg
  import wisc_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int RA_W  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             flush,
  input  logic             ex_valid,
  input  logic [3:0]       ex_opcode,
  input  logic [WIDTH-1:0] ex_result,
  input  logic             ex_ovf,
  input  logic [RA_W-1:0]  ex_rd,
  input  logic             ex_reg_wr,
  input  logic             ex_mem_rd,
  input  logic             ex_mem_wr,
  input  logic [WIDTH-1:0] ex_store_data,
  output logic             mem_valid,
  output logic [3:0]       mem_opcode,
  output logic [WIDTH-1:0] mem_result,
  output logic [RA_W-1:0]  mem_rd,
  output logic             mem_reg_wr,
  output logic             mem_mem_rd,
  output logic             mem_mem_wr,
  output logic [WIDTH-1:0] mem_store_data,
  output logic             flag_z,
  output logic             flag_v,
  output logic             flag_n,
  output logic [2:0]       flags_fwd,
  output logic             halted
);

  logic accept, load;

  assign accept = ex_valid & ~stall & ~flush & ~halted;
  // Flush overrides stall; once halted the data registers simply hold.
  assign load   = ~halted & (flush | ~stall);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_valid      <= 1'b0;
      mem_opcode     <= '0;
      mem_result     <= '0;
      mem_rd         <= '0;
      mem_reg_wr     <= 1'b0;
      mem_mem_rd     <= 1'b0;
      mem_mem_wr     <= 1'b0;
      mem_store_data <= '0;
      halted         <= 1'b0;
    end else if (halted) begin
      mem_valid  <= 1'b0;
      mem_reg_wr <= 1'b0;
      mem_mem_rd <= 1'b0;
      mem_mem_wr <= 1'b0;
    end else if (load) begin
      mem_valid      <= accept;
      mem_opcode     <= ex_opcode;
      mem_result     <= ex_result;
      mem_rd         <= ex_rd;
      mem_reg_wr     <= accept & ex_reg_wr;
      mem_mem_rd     <= accept & ex_mem_rd;
      mem_mem_wr     <= accept & ex_mem_wr;
      mem_store_data <= ex_store_data;
      if (accept && ex_opcode == OP_HLT) halted <= 1'b1;
    end
  end

  flag_unit #(.WIDTH(WIDTH)) u_flags (
    .clk       (clk),
    .rst       (rst),
    .upd       (accept),
    .opcode    (ex_opcode),
    .result    (ex_result),
    .ovf       (ex_ovf),
    .flag_z    (flag_z),
    .flag_v    (flag_v),
    .flag_n    (flag_n),
    .flags_fwd (flags_fwd)
  );

endmodule

// File: doc/ex_mem_flag_reg.md
Name: ex_mem_flag_reg

Overview:
- EX/MEM pipeline register that captures the execute-stage result (barrel shifter or ALU output) and the condition-flag register (Z, V, N) that the result updates.
- Sits directly downstream of the execute-stage shifter/ALU result mux and feeds the memory stage and the branch-condition logic.
- Handles stall, flush and the HLT sticky-halt condition.

Parameters:
- WIDTH, 16, datapath width.
- RA_W, 4, register-file address width.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- stall  in  1  hold all registered state this cycle.
- flush  in  1  replace the incoming EX instruction with a bubble.
- ex_valid  in  1  EX slot holds a real instruction.
- ex_opcode  in  4  EX instruction opcode.
- ex_result  in  WIDTH  shifter/ALU result.
- ex_ovf  in  1  signed overflow from the adder (ADD/SUB only).
- ex_rd  in  RA_W  destination register.
- ex_reg_wr  in  1  register write enable.
- ex_mem_rd  in  1  load.
- ex_mem_wr  in  1  store.
- ex_store_data  in  WIDTH  store data.
- mem_valid  out  1  registered copy of the valid bit.
- mem_opcode  out  4  registered opcode.
- mem_result  out  WIDTH  registered result.
- mem_rd  out  RA_W  registered destination register.
- mem_reg_wr  out  1  registered register write enable.
- mem_mem_rd  out  1  registered load control.
- mem_mem_wr  out  1  registered store control.
- mem_store_data  out  WIDTH  registered store data.
- flag_z, flag_v, flag_n  out  1 each  architectural flags.
- flags_fwd  out  3  {Z,V,N} value the flags will hold after the next edge (combinational).
- halted  out  1  sticky; set by HLT.

Behaviour:
- Reset, asynchronous, active-high: every output register clears to 0, including mem_valid, all controls, mem_result, flags and halted.
- Latency: 1 cycle, EX to MEM.
- Accept condition: accept = ex_valid & ~stall & ~flush & ~halted.
- Priority per edge: rst > halted > flush > stall > normal.
- Normal (accept): every mem_* register loads its ex_* counterpart; mem_valid=1.
- Invalid EX slot: ex_valid=0 with no stall/flush loads a bubble: mem_valid=0, mem_reg_wr=mem_mem_rd=mem_mem_wr=0. Data registers still load; their values are don't-care.
- Flush (overrides stall if both are asserted): loads a bubble exactly as above. Flags are not updated.
- Stall, without flush: every register holds, including flags.
- Flag update happens only on accept:
  - ADD (0000), SUB (0001): Z=(ex_result==0), N=ex_result[WIDTH-1], V=ex_ovf.
  - XOR (0010), SLL (0100), SRA (0101), ROR (0110): Z only; V and N hold.
  - All other opcodes: flags hold.
- flags_fwd: equals the post-edge flag values under the above rules, including the hold cases. It lets a branch in decode resolve in the same cycle.
- HLT (1111) accepted:
  - Passes to MEM normally (mem_valid=1).
  - halted=1 on that same edge.
  - From the next edge on: every edge loads a bubble regardless of inputs; flags frozen; flags_fwd = current flags.
  - Cleared only by rst.
- Reset asserted mid-operation clears immediately, with no dependence on clk.
- Shifter mode equals ex_opcode[1:0] for opcodes 01xx; no decode is performed here beyond the flag masks.

Decomposition:
- Shared package wisc_pkg:
  - opcode localparams OP_ADD … OP_HLT;
  - flag index constants FLAG_Z=2, FLAG_V=1, FLAG_N=0;
  - helper function returning a 3-bit flag write mask per opcode.
- One sub-module, flag_unit: flag registers, update-mask logic and flags_fwd. The top module holds the pipeline registers and halt logic.

Test Plan:
- Reset mid-run: drive traffic, assert rst asynchronously between edges -> all outputs 0 immediately; flags_fwd=000.
- ADD, ex_result=16'h0000, ex_ovf=1, accept -> next cycle mem_valid=1, mem_result=0000, Z=1, V=1, N=0.
- SUB 16'h8001 (sets N=1, Z=0), then SLL with result 16'h0000 -> Z=1, V and N held from SUB; flags_fwd shows 1,x,1 during the SLL cycle before the edge.
- Stall=1 for 3 cycles with varying ex_* inputs -> mem_* and flags unchanged. Stall+flush together with ADD result 0 -> mem_valid=0, reg_wr=0, flags unchanged.
- LW with ex_rd=5 and mem_rd=1, followed by ex_valid=0 -> LW appears in MEM for exactly one cycle; the next cycle is a bubble with all controls 0.
- HLT accepted, then ADD result 0 presented -> halted=1 after the HLT edge; the ADD never reaches MEM (mem_valid=0); Z unchanged; halted stays 1 until rst.
